// File: rtl/usr_shift_param.sv
// Parametrised universal shift register (hold / right / left / load) with external,
// ring or Johnson feedback and a period step counter. Optional macro: USR_SELFCORRECT_EN.
module usr_shift_param #(
  parameter int WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           CLR,
  input  logic                           S1,
  input  logic                           S0,
  input  logic [1:0]                     FB,
  input  logic                           RIN,
  input  logic                           LIN,
  input  logic [WIDTH-1:0]               D,
  output logic [WIDTH-1:0]               Q,
  output logic [$clog2(2*WIDTH)-1:0]     CNT,
  output logic                           WRAP
);

  localparam int CW = $clog2(2*WIDTH);
  // Last count value before a wrap; one extra bit so 2*WIDTH-1 always fits.
  localparam logic [CW:0] LAST_STD  = (CW+1)'(WIDTH - 1);
  localparam logic [CW:0] LAST_JOHN = (CW+1)'(2*WIDTH - 1);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_LEFT  = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    FB_EXT     = 2'b00,
    FB_RING    = 2'b01,
    FB_JOHNSON = 2'b10,
    FB_EXT_ALT = 2'b11
  } fb_t;

  mode_t            mode;
  fb_t              fb_sel;
  logic             r_bit;
  logic             l_bit;
  logic [WIDTH-1:0] shifted;
  logic [CW:0]      last;
  logic             at_end;
  logic             illegal;

  assign mode   = mode_t'({S1, S0});
  assign fb_sel = fb_t'(FB);

  // NOTE: every signal gets a default at the top of always_comb, so no path leaves it unassigned (no latch).
  always_comb begin
    r_bit = RIN;
    l_bit = LIN;
    case (fb_sel)
      FB_RING: begin
        r_bit = Q[0];
        l_bit = Q[WIDTH-1];
      end
      FB_JOHNSON: begin
        r_bit = ~Q[0];
        l_bit = ~Q[WIDTH-1];
      end
      default: ;
    endcase
    shifted = (mode == MODE_LEFT) ? {Q[WIDTH-2:0], l_bit} : {r_bit, Q[WIDTH-1:1]};
    last    = (fb_sel == FB_JOHNSON) ? LAST_JOHN : LAST_STD;
    // ">=" rather than "==": a count left beyond the period by an FB change wraps on the next shift.
    at_end  = {1'b0, CNT} >= last;
  end

`ifdef USR_SELFCORRECT_EN
  // A legal Johnson code has at most one adjacent bit transition: zero or one bit set in edges.
  logic [WIDTH-2:0] edges;
  assign edges   = Q[WIDTH-1:1] ^ Q[WIDTH-2:0];
  assign illegal = (fb_sel == FB_JOHNSON) && ((edges & (edges - (WIDTH-1)'(1))) != '0);
`else
  assign illegal = 1'b0;
`endif

  // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (CLR) begin
      Q    <= '0;
      CNT  <= '0;
      WRAP <= 1'b0;
    end else begin
      WRAP <= 1'b0;
      case (mode)
        MODE_HOLD: ;
        MODE_LOAD: begin
          Q   <= D;
          CNT <= '0;
        end
        default: begin
          if (illegal) begin
            Q   <= '0;
            CNT <= '0;
          end else begin
            Q <= shifted;
            if (at_end) begin
              CNT  <= '0;
              WRAP <= 1'b1;
            end else begin
              CNT <= CNT + CW'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usr_shift_param.sv
// Self-checking bench for usr_shift_param (WIDTH=4): per-cycle comparison against a
// behavioural model plus hand-computed directed expectations.
module tb_usr_shift_param;

  localparam int W  = 4;
  localparam int CW = $clog2(2*W);

  logic          clk = 1'b0;
  logic          CLR = 1'b0;
  logic          S1 = 1'b0, S0 = 1'b0;
  logic [1:0]    FB = 2'b00;
  logic          RIN = 1'b0, LIN = 1'b0;
  logic [W-1:0]  D = '0;
  logic [W-1:0]  Q;
  logic [CW-1:0] CNT;
  logic          WRAP;

  int n_cmp = 0;
  int n_bad = 0;

  usr_shift_param #(.WIDTH(W)) dut (
    .clk(clk), .CLR(CLR), .S1(S1), .S0(S0), .FB(FB),
    .RIN(RIN), .LIN(LIN), .D(D), .Q(Q), .CNT(CNT), .WRAP(WRAP)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_q;
  int           m_cnt;
  logic         m_wrap;
  bit           m_valid = 0;

  // Legal Johnson codes are exactly the 2W states visited by the Johnson sequence from zero.
  function automatic bit johnson_legal(input logic [W-1:0] v);
    logic [W-1:0] s = '0;
    for (int i = 0; i < 2*W; i++) begin
      if (s == v) return 1'b1;
      s = {s[W-2:0], ~s[W-1]};
    end
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    int   period;
    logic in_bit;
    if (CLR) begin
      m_q = '0; m_cnt = 0; m_wrap = 0; m_valid = 1;
    end else if (m_valid) begin
      m_wrap = 0;
      period = (FB == 2'b10) ? 2*W : W;
      case ({S1, S0})
        2'b00: ;
        2'b11: begin m_q = D; m_cnt = 0; end
        default: begin
`ifdef USR_SELFCORRECT_EN
          if (FB == 2'b10 && !johnson_legal(m_q)) begin
            m_q = '0; m_cnt = 0;
          end else
`endif
          begin
            if ({S1, S0} == 2'b01) begin
              in_bit = (FB == 2'b01) ? m_q[0] : (FB == 2'b10) ? ~m_q[0] : RIN;
              m_q = (m_q >> 1) | (W'(in_bit) << (W-1));
            end else begin
              in_bit = (FB == 2'b01) ? m_q[W-1] : (FB == 2'b10) ? ~m_q[W-1] : LIN;
              m_q = (m_q << 1) | W'(in_bit);
            end
            if (m_cnt + 1 >= period) begin m_cnt = 0; m_wrap = 1; end
            else m_cnt = m_cnt + 1;
          end
        end
      endcase
    end
  end

  // Compare process: outputs checked on the falling edge every cycle once reset has been seen.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_q",    32'(Q),    32'(m_q));
      check("model_cnt",  32'(CNT),  32'(m_cnt));
      check("model_wrap", 32'(WRAP), 32'(m_wrap));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic clr, input logic [1:0] s, input logic [1:0] fb,
                      input logic rin = 1'b0, input logic lin = 1'b0,
                      input logic [W-1:0] d = '0);
    CLR = clr; {S1, S0} = s; FB = fb; RIN = rin; LIN = lin; D = d;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic expect_state(input string name, input logic [W-1:0] q,
                              input int cnt, input logic wrap);
    check({name, "_q"},    32'(Q),    32'(q));
    check({name, "_cnt"},  32'(CNT),  32'(cnt));
    check({name, "_wrap"}, 32'(WRAP), 32'(wrap));
  endtask

  logic [W-1:0] john_seq [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                 4'b1110, 4'b1100, 4'b1000, 4'b0000};
  logic [W-1:0] ring_seq [4] = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
  logic         rin_pat  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    @(negedge clk);
    step(1, 2'b00, 2'b00);
    expect_state("init_clr", 4'b0000, 0, 0);

    // Reach Q=1010, CNT=2: load 1000, then shift right with RIN 0 then 1.
    step(0, 2'b11, 2'b00, 0, 0, 4'b1000);
    step(0, 2'b01, 2'b00, 0);
    step(0, 2'b01, 2'b00, 1);
    expect_state("pre_reset", 4'b1010, 2, 0);
    step(1, 2'b10, 2'b00);
    expect_state("reset", 4'b0000, 0, 0);

    // Johnson left: full 8-step period, wrap only after the 8th edge.
    for (int i = 0; i < 8; i++) begin
      step(0, 2'b10, 2'b10);
      expect_state($sformatf("john%0d", i), john_seq[i], (i + 1) % 8, i == 7);
    end

    // FB change mid-period: CNT=6 under Johnson exceeds ring's period, next shift wraps.
    for (int i = 0; i < 6; i++) step(0, 2'b10, 2'b10);
    expect_state("fbchg_pre", 4'b1100, 6, 0);
    step(0, 2'b01, 2'b01);
    expect_state("fbchg_wrap", 4'b0110, 0, 1);
    step(0, 2'b01, 2'b01);
    expect_state("fbchg_next", 4'b0011, 1, 0);

    // Ring right from a loaded 1000.
    step(0, 2'b11, 2'b01, 0, 0, 4'b1000);
    expect_state("ring_load", 4'b1000, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 2'b01, 2'b01);
      expect_state($sformatf("ring%0d", i), ring_seq[i], (i + 1) % 4, i == 3);
    end

    // External serial right, then hold.
    step(1, 2'b00, 2'b00);
    for (int i = 0; i < 4; i++) step(0, 2'b01, 2'b00, rin_pat[i]);
    expect_state("ext_wrap", 4'b1101, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 2'b00, 2'b00, 1, 1);
      expect_state($sformatf("hold%0d", i), 4'b1101, 0, 0);
    end

    // FB=11 behaves as external: shift left with LIN.
    step(0, 2'b10, 2'b11, 0, 1);
    expect_state("fb11_left", 4'b1011, 1, 0);

    // Mid-period load then CLR (asserted together with a load) aborts without WRAP.
    step(1, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) step(0, 2'b10, 2'b10);
    expect_state("mid_pre", 4'b0111, 3, 0);
    step(0, 2'b11, 2'b10, 0, 0, 4'b0110);
    expect_state("mid_load", 4'b0110, 0, 0);
    step(0, 2'b10, 2'b10);
    check("mid_s1_wrap", 32'(WRAP), 32'(0));
    step(0, 2'b10, 2'b10);
    check("mid_s2_wrap", 32'(WRAP), 32'(0));
    step(1, 2'b11, 2'b10, 0, 0, 4'b1111);
    expect_state("mid_clr", 4'b0000, 0, 0);

    // Illegal Johnson code 0101, one shift left. Plain shift appends ~Q[3]=1 -> 1011.
    step(0, 2'b11, 2'b10, 0, 0, 4'b0101);
    step(0, 2'b10, 2'b10);
`ifdef USR_SELFCORRECT_EN
    expect_state("selfcorr", 4'b0000, 0, 0);
`else
    expect_state("selfcorr", 4'b1011, 1, 0);
`endif

    step(0, 2'b00, 2'b00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
